// File: rtl/reorder_buffer.sv
// Circular reorder buffer: up to 4-wide dispatch, 2 writeback ports, in-order
// commit of up to 4 entries per cycle with compacted stale-register release.

module rob_entry #(
    parameter int PBITS = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_alloc,
    input  logic             i_has_rd,
    input  logic [PBITS-1:0] i_old_p,
    input  logic             i_wb,
    input  logic             i_retire,
    output logic             o_valid,
    output logic             o_done,
    output logic             o_has_rd,
    output logic [PBITS-1:0] o_old_p
);

    // Allocation and retirement target disjoint regions, so their order is moot;
    // retirement must beat writeback so a retiring entry does not stay done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
            o_has_rd <= 1'b0;
            o_old_p  <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
        end else if (i_alloc) begin
            o_valid  <= 1'b1;
            o_done   <= 1'b0;
            o_has_rd <= i_has_rd;
            o_old_p  <= i_old_p;
        end else if (i_retire) begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
        end else if (i_wb && o_valid) begin
            o_done <= 1'b1;
        end
    end

endmodule

module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int PBITS = 6,
    parameter int IBITS = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_disp_count,
    input  logic             i_disp_has_rd0,
    input  logic             i_disp_has_rd1,
    input  logic             i_disp_has_rd2,
    input  logic             i_disp_has_rd3,
    input  logic [PBITS-1:0] i_disp_old_p0,
    input  logic [PBITS-1:0] i_disp_old_p1,
    input  logic [PBITS-1:0] i_disp_old_p2,
    input  logic [PBITS-1:0] i_disp_old_p3,
    input  logic             i_wb_valid0,
    input  logic             i_wb_valid1,
    input  logic [IBITS-1:0] i_wb_idx0,
    input  logic [IBITS-1:0] i_wb_idx1,
    input  logic             i_flush,
    output logic [IBITS-1:0] o_tail,
    output logic [IBITS:0]   o_free_count,
    output logic [PBITS-1:0] o_ret_p0,
    output logic [PBITS-1:0] o_ret_p1,
    output logic [PBITS-1:0] o_ret_p2,
    output logic [PBITS-1:0] o_ret_p3,
    output logic [2:0]       o_ret_count,
    output logic [2:0]       o_commit_count
);

    localparam int LANES = 4;

    logic [IBITS-1:0]                  head, tail;
    logic [IBITS:0]                    count, count_next;
    logic [DEPTH-1:0]                  ent_valid, ent_done, ent_has_rd;
    logic [DEPTH-1:0][PBITS-1:0]       ent_old_p;
    logic [LANES-1:0]                  disp_has_rd;
    logic [LANES-1:0][PBITS-1:0]       disp_old_p;
    logic                              disp_ok;
    logic [2:0]                        disp_n, commit_n, ret_n;
    logic [LANES-1:0][PBITS-1:0]       ret_p;
    logic [LANES-1:0][PBITS-1:0]       ret_p_q;
    logic [2:0]                        ret_n_q, commit_n_q;
    logic                              run;
    logic [IBITS-1:0]                  cidx, ridx;

    assign disp_has_rd = {i_disp_has_rd3, i_disp_has_rd2, i_disp_has_rd1, i_disp_has_rd0};
    assign disp_old_p  = {i_disp_old_p3, i_disp_old_p2, i_disp_old_p1, i_disp_old_p0};

    assign o_free_count = (IBITS+1)'(DEPTH) - count;

    // Whole group or nothing, checked against pre-commit free space.
    assign disp_ok = (i_disp_count <= 3'd4) && ((IBITS+1)'(i_disp_count) <= o_free_count);
    assign disp_n  = disp_ok ? i_disp_count : 3'd0;

    always_comb begin
        commit_n = 3'd0;
        run      = 1'b1;
        cidx     = '0;
        for (int k = 0; k < LANES; k++) begin
            cidx = head + IBITS'(k);
            if (run && ent_valid[cidx] && ent_done[cidx] && ((IBITS+1)'(k) < count))
                commit_n = commit_n + 3'd1;
            else
                run = 1'b0;
        end
    end

    // Pack released registers in program order; unused lanes stay zero.
    always_comb begin
        ret_p = '0;
        ret_n = 3'd0;
        ridx  = '0;
        for (int k = 0; k < LANES; k++) begin
            ridx = head + IBITS'(k);
            if ((3'(k) < commit_n) && ent_has_rd[ridx]) begin
                ret_p[ret_n[1:0]] = ent_old_p[ridx];
                ret_n = ret_n + 3'd1;
            end
        end
    end

    assign count_next = count + (IBITS+1)'(disp_n) - (IBITS+1)'(commit_n);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ret_p_q    <= '0;
            ret_n_q    <= 3'd0;
            commit_n_q <= 3'd0;
        end else begin
            head       <= head + IBITS'(commit_n);
            tail       <= tail + IBITS'(disp_n);
            count      <= count_next;
            ret_p_q    <= ret_p;
            ret_n_q    <= ret_n;
            commit_n_q <= commit_n;
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        logic [IBITS-1:0] toff, hoff;
        logic             alloc, retire, wb_hit;

        // Offsets from tail/head tell each entry which dispatch slot or retire lane it is.
        assign toff   = IBITS'(e) - tail;
        assign hoff   = IBITS'(e) - head;
        assign alloc  = {1'b0, toff} < (IBITS+1)'(disp_n);
        assign retire = {1'b0, hoff} < (IBITS+1)'(commit_n);
        assign wb_hit = (i_wb_valid0 && (i_wb_idx0 == IBITS'(e))) ||
                        (i_wb_valid1 && (i_wb_idx1 == IBITS'(e)));

        rob_entry #(.PBITS(PBITS)) u_ent (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_flush  (i_flush),
            .i_alloc  (alloc),
            .i_has_rd (disp_has_rd[toff[1:0]]),
            .i_old_p  (disp_old_p[toff[1:0]]),
            .i_wb     (wb_hit),
            .i_retire (retire),
            .o_valid  (ent_valid[e]),
            .o_done   (ent_done[e]),
            .o_has_rd (ent_has_rd[e]),
            .o_old_p  (ent_old_p[e])
        );
    end

    assign o_tail         = tail;
    assign o_ret_p0       = ret_p_q[0];
    assign o_ret_p1       = ret_p_q[1];
    assign o_ret_p2       = ret_p_q[2];
    assign o_ret_p3       = ret_p_q[3];
    assign o_ret_count    = ret_n_q;
    assign o_commit_count = commit_n_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retire events
// into a scoreboard; a negedge monitor pops one per nonzero commit output.

module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] disp_count;
    logic       hrd0, hrd1, hrd2, hrd3;
    logic [5:0] op0, op1, op2, op3;
    logic       wv0, wv1;
    logic [3:0] wi0, wi1;
    logic       flush;
    logic [3:0] tail;
    logic [4:0] free_count;
    logic [5:0] rp0, rp1, rp2, rp3;
    logic [2:0] ret_count, commit_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]      rc;
        logic [2:0]      cc;
        logic [3:0][5:0] p;
    } exp_t;

    exp_t            sb[$];
    exp_t            cur;
    logic [3:0][5:0] act_p;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(16), .PBITS(6)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_disp_count   (disp_count),
        .i_disp_has_rd0 (hrd0),
        .i_disp_has_rd1 (hrd1),
        .i_disp_has_rd2 (hrd2),
        .i_disp_has_rd3 (hrd3),
        .i_disp_old_p0  (op0),
        .i_disp_old_p1  (op1),
        .i_disp_old_p2  (op2),
        .i_disp_old_p3  (op3),
        .i_wb_valid0    (wv0),
        .i_wb_valid1    (wv1),
        .i_wb_idx0      (wi0),
        .i_wb_idx1      (wi1),
        .i_flush        (flush),
        .o_tail         (tail),
        .o_free_count   (free_count),
        .o_ret_p0       (rp0),
        .o_ret_p1       (rp1),
        .o_ret_p2       (rp2),
        .o_ret_p3       (rp3),
        .o_ret_count    (ret_count),
        .o_commit_count (commit_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int rc, input int cc, input int a, input int b, input int c, input int d);
        exp_t e;
        e.rc = 3'(rc);
        e.cc = 3'(cc);
        e.p  = {6'(d), 6'(c), 6'(b), 6'(a)};
        sb.push_back(e);
    endtask

    task automatic disp(input logic [2:0] n, input logic [3:0] hrd,
                        input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
        disp_count = n;
        {hrd3, hrd2, hrd1, hrd0} = hrd;
        op0 = a; op1 = b; op2 = c; op3 = d;
    endtask

    task automatic wb(input logic v0, input logic [3:0] i0, input logic v1, input logic [3:0] i1);
        wv0 = v0; wi0 = i0; wv1 = v1; wi1 = i1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        disp_count = 3'd0;
        {hrd3, hrd2, hrd1, hrd0} = 4'b0;
        wv0 = 1'b0; wv1 = 1'b0;
        flush = 1'b0;
    endtask

    task automatic chk_ptrs(input string tag, input int t, input int f);
        chk({tag, "_tail"}, 32'(tail), 32'(t));
        chk({tag, "_free"}, 32'(free_count), 32'(f));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_ptrs(tag, 0, 16);
        chk({tag, "_ret_count"}, 32'(ret_count), 0);
        chk({tag, "_commit_count"}, 32'(commit_count), 0);
        chk({tag, "_ret_p"}, 32'({rp3, rp2, rp1, rp0}), 0);
    endtask

    // Every nonzero commit output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (commit_count != 3'd0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got commit_count %0d ret_count %0d, expected no commit",
                         commit_count, ret_count);
            end else begin
                cur   = sb.pop_front();
                act_p = {rp3, rp2, rp1, rp0};
                chk("sb_ret_count", 32'(ret_count), 32'(cur.rc));
                chk("sb_commit_count", 32'(commit_count), 32'(cur.cc));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("sb_ret_p%0d", k), 32'(act_p[k]), 32'(cur.p[k]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        disp(0, 4'b0, 0, 0, 0, 0);
        wb(0, 0, 0, 0);
        flush = 1'b0;
        step();
        step();
        chk_reset_outs("reset");
        rst = 1'b0;

        // 4-wide group, all with destinations; younger pair completes first
        disp(4, 4'b1111, 10, 11, 12, 13); step(); chk_ptrs("s1_disp", 4, 12);
        wb(1, 2, 1, 3); step();
        wb(1, 0, 1, 1); push(4, 4, 10, 11, 12, 13); step();
        step(); chk_ptrs("s1_drain", 4, 16);

        // Mixed has_rd: releases compact to p0/p1
        disp(4, 4'b0101, 5, 33, 7, 44); step();
        wb(1, 6, 1, 7); step();
        wb(1, 4, 1, 5); push(2, 4, 5, 7, 0, 0); step();
        step(); chk_ptrs("s2_drain", 8, 16);

        // Out-of-order completion blocks on head; duplicate writeback index
        disp(3, 4'b0111, 20, 21, 22, 0); step();
        wb(1, 9, 1, 10); step();
        step(); step(); chk_ptrs("s3_blocked", 11, 13);
        wb(1, 8, 1, 8); push(3, 3, 20, 21, 22, 0); step();
        step(); chk_ptrs("s3_drain", 11, 16);

        // No destinations: commit with zero releases, moves tail to 14
        disp(3, 4'b0000, 1, 2, 3, 0); step();
        wb(1, 12, 1, 13); step();
        wb(1, 11, 0, 0); push(0, 3, 0, 0, 0, 0); step();
        step(); chk_ptrs("s3b_drain", 14, 16);

        // Fill; first group wraps 15 -> 0
        disp(4, 4'b1111, 46, 47, 32, 33); step(); chk_ptrs("fill1", 2, 12);
        disp(4, 4'b1111, 34, 35, 36, 37); step(); chk_ptrs("fill2", 6, 8);
        disp(4, 4'b1111, 38, 39, 40, 41); step(); chk_ptrs("fill3", 10, 4);
        disp(4, 4'b1111, 42, 43, 44, 45); step(); chk_ptrs("fill4", 14, 0);
        disp(1, 4'b0001, 60, 0, 0, 0); step(); chk_ptrs("full_drop", 14, 0);
        wb(1, 14, 1, 15); step();
        disp(3, 4'b0111, 61, 62, 63, 0); push(2, 2, 46, 47, 0, 0); step();
        chk_ptrs("commit_drop", 14, 2);
        disp(2, 4'b0011, 50, 51, 0, 0); step(); chk_ptrs("wrap_accept", 0, 0);

        // Flush from full, then flush 6 entries with some done
        flush = 1'b1; step(); chk_ptrs("flush_full", 0, 16);
        disp(4, 4'b1111, 1, 2, 3, 4); step();
        disp(2, 4'b0011, 5, 6, 0, 0); step(); chk_ptrs("s5_six", 6, 10);
        wb(1, 1, 1, 2); step();
        flush = 1'b1; wb(1, 0, 0, 0); disp(4, 4'b1111, 7, 7, 7, 7); step();
        chk_ptrs("flush6", 0, 16);
        chk("flush6_ret_count", 32'(ret_count), 0);
        chk("flush6_commit_count", 32'(commit_count), 0);
        wb(1, 0, 1, 3); step();
        chk("post_flush_commit", 32'(commit_count), 0);
        disp(1, 4'b0001, 9, 0, 0, 0); step(); chk_ptrs("s5_redisp", 1, 15);
        step(); step();
        wb(1, 0, 0, 0); push(1, 1, 9, 0, 0, 0); step();
        step(); chk_ptrs("s5_drain", 1, 16);

        // Reset with commits pending: no release emitted
        disp(4, 4'b1111, 20, 21, 22, 23); step();
        wb(1, 1, 1, 2); step();
        rst = 1'b1; wb(1, 3, 1, 4); step();
        rst = 1'b0;
        chk_reset_outs("mid_reset");
        step(); step();
        disp(1, 4'b0001, 15, 0, 0, 0); step(); chk_ptrs("post_reset_disp", 1, 15);
        wb(1, 0, 0, 0); push(1, 1, 15, 0, 0, 0); step();
        step(); step();
        chk_ptrs("final", 1, 16);
        chk("sb_outstanding", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
